// File: rtl/lif_membrane_update.sv
// LIF membrane potential stage: leak, integrate with saturation,
// reset-on-spike and refractory hold, paired with an external spike generator.
module lif_membrane_update #(
  parameter int n_stage    = 2,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_step,
  input  logic [n_stage+1:0]   current_in,
  input  logic [n_stage+1:0]   theta,
  input  logic                 is_spike,
  output logic [n_stage+1:0]   u,
  output logic [n_stage+1:0]   minus_teta,
  output logic                 spike_out,
  output logic                 refractory
);

  localparam int W = n_stage + 2;

  localparam logic [0:0] INTEGRATE  = 1'b0;
  localparam logic [0:0] REFRACTORY = 1'b1;

  localparam logic [7:0] REF_CNT = 8'(REFRAC);
  localparam logic [W:0] U_MAX   = {1'b0, {W{1'b1}}};

  logic [0:0]   state;
  logic [7:0]   cnt;
  logic [W-1:0] leak;
  logic [W:0]   raw;
  logic [W-1:0] u_next;

  // theta=0 maps to 0, so the generator never carries and never fires
  assign minus_teta = ~theta + W'(1);
  assign refractory = (state == REFRACTORY);

  assign leak   = u >> LEAK_SHIFT;
  assign raw    = {1'b0, u} - {1'b0, leak} + {1'b0, current_in};
  assign u_next = raw[W] ? U_MAX[W-1:0] : raw[W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      u         <= '0;
      spike_out <= 1'b0;
      state     <= INTEGRATE;
      cnt       <= '0;
    end else begin
      spike_out <= 1'b0;
      if (en_step) begin
        unique case (state)
          INTEGRATE: begin
            if (is_spike) begin
              u         <= '0;
              spike_out <= 1'b1;
              if (REFRAC > 0) begin
                cnt   <= REF_CNT;
                state <= REFRACTORY;
              end
            end else begin
              u <= u_next;
            end
          end
          REFRACTORY: begin
            u <= '0;
            if (cnt == 8'd1) begin
              cnt   <= '0;
              state <= INTEGRATE;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: begin
            state <= INTEGRATE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lif_membrane_update.sv
// Table-driven scoreboard bench for lif_membrane_update with a
// behavioural carry-out spike generator closing the is_spike loop.
module tb_lif_membrane_update;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         en_step;
  logic [W-1:0] current_in;
  logic [W-1:0] theta;
  logic         is_spike;
  logic [W-1:0] u;
  logic [W-1:0] minus_teta;
  logic         spike_out;
  logic         refractory;
  logic [W:0]   gen_sum;

  lif_membrane_update #(
    .n_stage(2),
    .LEAK_SHIFT(1),
    .REFRAC(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en_step(en_step),
    .current_in(current_in),
    .theta(theta),
    .is_spike(is_spike),
    .u(u),
    .minus_teta(minus_teta),
    .spike_out(spike_out),
    .refractory(refractory)
  );

  assign gen_sum  = {1'b0, u} + {1'b0, minus_teta};
  assign is_spike = gen_sum[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] cur;
    logic [W-1:0] th;
    logic [W-1:0] eu;
    logic         espk;
    logic         eref;
    string        tag;
  } vec_t;

  typedef struct {
    logic [W-1:0] eu;
    logic         espk;
    logic         eref;
    string        tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   errors;

  task automatic add(input logic rst, input logic en,
                     input int cur, input int th,
                     input int eu, input logic espk,
                     input logic eref, input string tag);
    vec_t v;
    v.rst = rst; v.en = en;
    v.cur = W'(cur); v.th = W'(th);
    v.eu = W'(eu); v.espk = espk; v.eref = eref;
    v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    int   mt;
    @(negedge clk);
    reset = v.rst; en_step = v.en;
    current_in = v.cur; theta = v.th;
    #1;
    mt = (16 - int'(v.th)) % 16;
    chk({v.tag, "_minus_teta"}, int'(minus_teta), mt);
    e.eu = v.eu; e.espk = v.espk; e.eref = v.eref; e.tag = v.tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_u"}, int'(u), int'(e.eu));
    chk({e.tag, "_spike"}, int'(spike_out), int'(e.espk));
    chk({e.tag, "_refr"}, int'(refractory), int'(e.eref));
  endtask

  initial begin
    logic [W-1:0] tv [4];
    logic [W-1:0] mv [4];
    checks = 0; errors = 0;
    reset = 1'b1; en_step = 1'b1;
    current_in = 4'd15; theta = 4'd8;

    // reset dominates a live strobe
    add(1, 1, 15, 8, 0, 0, 0, "rst0");
    add(1, 1, 15, 8, 0, 0, 0, "rst1");
    // integrate 0->5->8, fire, refractory, resume
    add(0, 1, 5, 8, 5, 0, 0, "int1");
    add(0, 1, 5, 8, 8, 0, 0, "int2");
    add(0, 1, 5, 8, 0, 1, 1, "fire");
    add(0, 0, 5, 8, 0, 0, 1, "pulse_end");
    add(0, 1, 5, 8, 0, 0, 1, "refr1");
    add(0, 1, 5, 8, 0, 0, 0, "refr2");
    add(0, 1, 5, 8, 5, 0, 0, "resume");
    // strobe gating with u=5
    for (int i = 0; i < 10; i++)
      add(0, 0, 15, 8, 5, 0, 0, "gate");
    // saturation with theta=0
    add(1, 0, 0, 0, 0, 0, 0, "rst2");
    add(0, 1, 15, 0, 15, 0, 0, "sat1");
    add(0, 1, 15, 0, 15, 0, 0, "sat2");
    add(0, 1, 15, 0, 15, 0, 0, "sat3");
    // reset mid-refractory
    add(1, 0, 0, 8, 0, 0, 0, "rst3");
    add(0, 1, 5, 8, 5, 0, 0, "m_int1");
    add(0, 1, 5, 8, 8, 0, 0, "m_int2");
    add(0, 1, 5, 8, 0, 1, 1, "m_fire");
    add(1, 1, 5, 8, 0, 0, 0, "m_rst");
    add(0, 1, 3, 8, 3, 0, 0, "m_after");
    // leak only: 3 -> 3-1+0 = 2 -> 2-1 = 1
    add(0, 1, 0, 8, 2, 0, 0, "leak1");
    add(0, 1, 0, 8, 1, 0, 0, "leak2");

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i]);

    // combinational threshold path, no clock involved
    tv[0] = 4'd0; tv[1] = 4'd1; tv[2] = 4'd8; tv[3] = 4'd15;
    mv[0] = 4'd0; mv[1] = 4'd15; mv[2] = 4'd8; mv[3] = 4'd1;
    @(negedge clk);
    en_step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      theta = tv[i];
      #1;
      chk("mt_comb", int'(minus_teta), int'(mv[i]));
    end

    // lowered threshold fires on the very next strobe (u=1, theta=1)
    @(negedge clk);
    theta = 4'd1; en_step = 1'b1; current_in = 4'd7;
    @(posedge clk);
    #1;
    chk("th_change_spike", int'(spike_out), 1);
    chk("th_change_u", int'(u), 0);
    en_step = 1'b0;
    @(posedge clk);
    #1;
    chk("th_change_pulse", int'(spike_out), 0);

    if (sb.size() != 0)
      chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
